// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-stage SRAM controller:
// FSM state encoding, SRAM data width and default phase length.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam int SRAM_DW         = 16;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable 4-bit down-counter timing one halfword SRAM phase.
// Saturates at zero; next_zero lets the owner register strobes one cycle ahead.
module sram_phase_timer
  import mips_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero,
  output logic             next_zero
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // next count: reload wins, otherwise saturating decrement
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign zero      = (cnt_r == {CNT_W{1'b0}});
  assign next_zero = (cnt_nxt_s == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two halfword
// accesses on a 16-bit async SRAM and freezes the pipeline meanwhile.
module mem_stage_ctrl
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               freeze,
  output logic [31:0]        rdata,
  output logic               rdata_valid,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int               WA_W   = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t         state_r, state_nxt_s;
  logic [WA_W-1:0]    wa_r, wa_nxt_s;
  logic [31:0]        wdata_r, wdata_nxt_s;
  logic               wr_r, wr_nxt_s;
  logic [SRAM_DW-1:0] rdata_lo_r;
  logic [31:0]        rdata_r;
  logic               rdata_valid_r;
  logic               req_s, start_s, lo_cap_s, rd_done_s;
  logic               tmr_load_s, tmr_zero_s, tmr_next_zero_s;

  logic [SRAM_AW-1:0] sram_addr_r, sram_addr_nxt_s;
  logic [SRAM_DW-1:0] sram_dq_out_r, sram_dq_out_nxt_s;
  logic               sram_dq_oe_r, sram_dq_oe_nxt_s;
  logic               sram_we_n_r, sram_we_n_nxt_s;
  logic               sram_oe_n_r, sram_oe_n_nxt_s;
  logic               unused_s;

  assign unused_s  = ^{addr[31:SRAM_AW+1], addr[1:0]};
  assign req_s     = mem_r_en | mem_w_en;
  assign start_s   = (state_r == ST_IDLE) & req_s;
  assign lo_cap_s  = (state_r == ST_LO) & tmr_zero_s & ~wr_r;
  assign rd_done_s = (state_r == ST_HI) & tmr_zero_s & ~wr_r;
  assign freeze    = ~rst & req_s & (state_r != ST_DONE);

  sram_phase_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load_s),
    .load_val  (RELOAD),
    .zero      (tmr_zero_s),
    .next_zero (tmr_next_zero_s)
  );

  // next-state and timer reload
  always_comb begin
    state_nxt_s = state_r;
    tmr_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_LO;
          tmr_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_HI;
          tmr_load_s  = 1'b1;
        end else begin
          state_nxt_s = ST_LO;
        end
      end
      ST_HI: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_HI;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // request latch; a write wins when both enables are high
  always_comb begin
    wa_nxt_s    = wa_r;
    wdata_nxt_s = wdata_r;
    wr_nxt_s    = wr_r;
    if (start_s) begin
      wa_nxt_s    = addr[SRAM_AW:2];
      wdata_nxt_s = wdata;
      wr_nxt_s    = mem_w_en;
    end else begin
      wa_nxt_s    = wa_r;
      wdata_nxt_s = wdata_r;
      wr_nxt_s    = wr_r;
    end
  end

  // SRAM strobes computed for the coming cycle so they leave as registers
  always_comb begin
    sram_addr_nxt_s   = sram_addr_r;
    sram_dq_out_nxt_s = sram_dq_out_r;
    sram_dq_oe_nxt_s  = 1'b0;
    sram_we_n_nxt_s   = 1'b1;
    sram_oe_n_nxt_s   = 1'b1;
    if ((state_nxt_s == ST_LO) || (state_nxt_s == ST_HI)) begin
      sram_addr_nxt_s = {wa_nxt_s, (state_nxt_s == ST_HI)};
      if (wr_nxt_s) begin
        sram_dq_oe_nxt_s  = 1'b1;
        sram_dq_out_nxt_s = (state_nxt_s == ST_HI) ? wdata_nxt_s[31:16] : wdata_nxt_s[15:0];
        // release the strobe in the last cycle for address/data hold
        sram_we_n_nxt_s   = tmr_next_zero_s;
      end else begin
        sram_oe_n_nxt_s   = 1'b0;
      end
    end else begin
      sram_addr_nxt_s = sram_addr_r;
    end
  end

  // state, latched request and SRAM output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wa_r          <= {WA_W{1'b0}};
      wdata_r       <= 32'h0000_0000;
      wr_r          <= 1'b0;
      sram_addr_r   <= {SRAM_AW{1'b0}};
      sram_dq_out_r <= 16'h0000;
      sram_dq_oe_r  <= 1'b0;
      sram_we_n_r   <= 1'b1;
      sram_oe_n_r   <= 1'b1;
    end else begin
      state_r       <= state_nxt_s;
      wa_r          <= wa_nxt_s;
      wdata_r       <= wdata_nxt_s;
      wr_r          <= wr_nxt_s;
      sram_addr_r   <= sram_addr_nxt_s;
      sram_dq_out_r <= sram_dq_out_nxt_s;
      sram_dq_oe_r  <= sram_dq_oe_nxt_s;
      sram_we_n_r   <= sram_we_n_nxt_s;
      sram_oe_n_r   <= sram_oe_n_nxt_s;
    end
  end

  // read data assembly; rdata changes only when a load completes
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_lo_r    <= 16'h0000;
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
    end else begin
      if (lo_cap_s) begin
        rdata_lo_r <= sram_dq_in;
      end
      if (rd_done_s) begin
        rdata_r <= {sram_dq_in, rdata_lo_r};
      end
      rdata_valid_r <= rd_done_s;
    end
  end

  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign sram_addr   = sram_addr_r;
  assign sram_dq_out = sram_dq_out_r;
  assign sram_dq_oe  = sram_dq_oe_r;
  assign sram_we_n   = sram_we_n_r;
  assign sram_oe_n   = sram_oe_n_r;

endmodule
